linear_interpolator: RTL

//  Upsampling interpolator. It raises the rate of a 24-bit signed sample stream by L = 2^SHIFT,

---
 rtl/linear_interpolator_pkg.sv | 18 +
 rtl/linear_interpolator_adder.sv | 15 +
 rtl/linear_interpolator.sv | 113 +++++++++++
 3 files changed

// File: rtl/linear_interpolator_pkg.sv
// Shared types and defaults for the linear upsampling interpolator.
package linear_interpolator_pkg;

    // Burst controller states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 24;
    localparam int DEF_SHIFT = 3;

    // Number of output samples produced per input sample
    function automatic int upsample_factor(input int shift);
        return 1 << shift;
    endfunction

endpackage

// File: rtl/linear_interpolator_adder.sv
// Generic N-bit two's-complement adder used for the accumulator step.
module linear_interpolator_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_sum
);

    // Plain wrap-around sum; the caller guarantees no overflow
    always_comb begin
        o_sum = i_a + i_b;
    end

endmodule

// File: rtl/linear_interpolator.sv
// Linear upsampling interpolator: each accepted input X produces L = 2^SHIFT
// outputs stepping from the previous sample P towards X, floor-rounded.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for the next input sample, IN_READY high
// RUN   | emitting the L interpolated points of the current burst
module linear_interpolator
    import linear_interpolator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int L    = upsample_factor(SHIFT);
    localparam int ACCW = WIDTH + SHIFT + 1;
    localparam logic [SHIFT-1:0] CNT_LAST = SHIFT'(L - 1);

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_p;
    logic [WIDTH:0]     r_diff;
    logic [ACCW-1:0]    r_acc;
    logic [SHIFT-1:0]   r_cnt;

    logic [WIDTH:0]     w_diff_next;
    logic [ACCW-1:0]    w_acc_start;
    logic [ACCW-1:0]    w_diff_ext;
    logic [ACCW-1:0]    w_acc_next;

    // Step size and burst start point, both sign-extended before arithmetic
    always_comb begin
        w_diff_next = {IN_DATA[WIDTH-1], IN_DATA} - {r_p[WIDTH-1], r_p};
        w_acc_start = {{(SHIFT + 1){r_p[WIDTH-1]}}, r_p} << SHIFT;
        w_diff_ext  = {{SHIFT{r_diff[WIDTH]}}, r_diff};
    end

    linear_interpolator_adder #(
        .N (ACCW)
    ) u_acc_adder (
        .i_a   (r_acc),
        .i_b   (w_diff_ext),
        .o_sum (w_acc_next)
    );

    // Burst controller: accepts one sample, then walks acc by diff L times
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_x         <= '0;
            r_p         <= '0;
            r_diff      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_out_valid <= 1'b0;
                    if (IN_VALID && r_in_ready) begin
                        r_x         <= IN_DATA;
                        r_diff      <= w_diff_next;
                        r_acc       <= w_acc_start;
                        r_cnt       <= '0;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_RUN;
                    end else begin
                        r_in_ready  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_in_ready <= 1'b0;
                    if (OUT_READY) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_p         <= r_x;
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // acc holds (P << SHIFT) + k*diff; its upper slice is the floor of acc / L
    always_comb begin
        OUT_DATA  = r_acc[SHIFT +: WIDTH];
        IN_READY  = r_in_ready;
        OUT_VALID = r_out_valid;
    end

endmodule
